// File: rtl/triangle_store.sv
// Triangle memory: bootloader write port with load tracking, and a valid/ready
// read stream of triangles 0..tri_count-1 from a single synchronous-read RAM.
module triangle_store #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 144,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_clr,
    input  logic                  wr_en,
    input  logic [31:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    output logic                  tri_valid,
    input  logic                  tri_ready,
    output logic [DATA_WIDTH-1:0] tri_data,
    output logic                  tri_last,
    output logic                  done,
    output logic                  busy,
    output logic [AW:0]           tri_count,
    output logic                  ovf
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t                state_reg, state_next;
    logic [AW:0]           rd_ptr_reg, rd_ptr_next;
    logic [AW:0]           count_reg, count_next, count_base;
    logic                  valid_reg, valid_next;
    logic                  last_reg, last_next;
    logic                  done_reg;
    logic                  ovf_reg, ovf_next;
    logic                  issue;
    logic                  wr_ok;
    logic [AW:0]           wr_top;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Full 32-bit compare so out-of-range addresses never alias onto valid slots.
    assign wr_ok  = !rst && wr_en && (state_reg == IDLE) && (wr_addr < 32'(DEPTH));
    assign wr_top = {1'b0, wr_addr[AW-1:0]} + (AW+1)'(1);

    always_comb begin
        count_base = load_clr ? '0 : count_reg;
        count_next = count_base;
        if (wr_ok && (wr_top > count_base))
            count_next = wr_top;
        ovf_next = load_clr ? 1'b0 : ovf_reg;
        if (wr_en && !wr_ok)
            ovf_next = 1'b1;
    end

    always_comb begin
        state_next  = state_reg;
        rd_ptr_next = rd_ptr_reg;
        valid_next  = valid_reg;
        last_next   = last_reg;
        issue       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    rd_ptr_next = '0;
                    state_next  = (count_reg != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                issue = (!valid_reg || tri_ready) && (rd_ptr_reg < count_reg);
                if (issue) begin
                    rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
                    valid_next  = 1'b1;
                    last_next   = (rd_ptr_reg == count_reg - (AW+1)'(1));
                end else if (valid_reg && tri_ready) begin
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                end
                // >= keeps the stream from stalling forever if the count shrinks underneath it
                if (rd_ptr_next >= count_reg)
                    state_next = FLUSH;
            end
            FLUSH: begin
                if (!valid_reg || tri_ready) begin
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            last_reg   <= 1'b0;
            done_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= valid_next;
            last_reg   <= last_next;
            done_reg   <= (state_reg == DONE);
            ovf_reg    <= ovf_next;
        end
    end

    // Read enable is issue alone, so the output word holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr[AW-1:0]] <= wr_data;
        if (issue)
            rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end

    assign tri_valid = valid_reg;
    assign tri_data  = rd_data_reg;
    assign tri_last  = last_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != IDLE);
    assign tri_count = count_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_triangle_store.sv
// Directed-plus-random bench for triangle_store against a slot-array model of
// the loaded triangles, their count and the overflow flag.
module tb_triangle_store;

    localparam int DEPTH = 1024;
    localparam int DW    = 144;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          tri_valid;
    logic          tri_ready = 1'b0;
    logic [DW-1:0] tri_data;
    logic          tri_last;
    logic          done;
    logic          busy;
    logic [AW:0]   tri_count;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_mem [DEPTH];
    int            model_count = 0;
    bit            model_ovf   = 1'b0;

    triangle_store #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .load_clr(load_clr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_data(tri_data),
        .tri_last(tri_last), .done(done), .busy(busy),
        .tri_count(tri_count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] v = '0;
        for (int i = 0; i < 5; i++) v = {v[DW-33:0], 32'($urandom)};
        return v;
    endfunction

    function automatic logic ready_pat(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic wr(input logic [31:0] a, input logic [DW-1:0] d, input bit clr);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d; load_clr = clr;
        if (clr) begin model_count = 0; model_ovf = 1'b0; end
        if (a < 32'(DEPTH)) begin
            model_mem[a[AW-1:0]] = d;
            if (int'(a) + 1 > model_count) model_count = int'(a) + 1;
        end else begin
            model_ovf = 1'b1;
        end
        @(posedge clk); #1;
        wr_en = 1'b0; load_clr = 1'b0;
        $display("write addr=%0h clr=%0d -> model count=%0d ovf=%0d", a, clr, model_count, model_ovf);
    endtask

    task automatic clr_load();
        @(negedge clk);
        load_clr = 1'b1; model_count = 0; model_ovf = 1'b0;
        @(posedge clk); #1;
        load_clr = 1'b0;
        $display("load_clr");
    endtask

    task automatic check_regs(input string tag);
        @(negedge clk);
        chk({tag, "_count"}, DW'(tri_count), DW'(model_count));
        chk({tag, "_ovf"}, DW'(ovf), DW'(model_ovf));
    endtask

    // Starts a stream and checks every beat, stall stability and done timing.
    // mode 0: ready always high (cycle-exact checks), 1: 1,0,0 pattern, 2: random.
    task automatic run_stream(input int mode, input bit inject_wr, input string tag);
        int n = model_count;
        int beats = 0;
        int done_k = -1;
        int budget = n * 4 + 20;
        logic [DW-1:0] pdata = '0;
        logic plast = 1'b0, pvalid = 1'b0, pacc = 1'b0;
        @(negedge clk);
        start = 1'b1;
        tri_ready = ready_pat(mode, 0);
        for (int k = 1; k < budget && done_k < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (inject_wr && k == 3) begin
                wr_en = 1'b1; wr_addr = 32'd0; wr_data = ~model_mem[0];
                model_ovf = 1'b1;
            end
            if (k == 1) chk({tag, "_busy"}, DW'(busy), DW'(1));
            if (pvalid && !pacc) begin
                chk({tag, "_hold_valid"}, DW'(tri_valid), DW'(1));
                chk({tag, "_hold_data"}, tri_data, pdata);
                chk({tag, "_hold_last"}, DW'(tri_last), DW'(plast));
            end
            if (done) begin
                done_k = k;
                chk({tag, "_done_busy"}, DW'(busy), DW'(0));
                chk({tag, "_beats"}, DW'(beats), DW'(n));
                if (mode == 0) chk({tag, "_done_cycle"}, DW'(k), DW'(n == 0 ? 2 : n + 3));
            end
            tri_ready = ready_pat(mode, k);
            pacc = tri_valid && tri_ready;
            if (tri_valid && tri_ready) begin
                if (beats < n) begin
                    chk({tag, "_data"}, tri_data, model_mem[beats]);
                    chk({tag, "_last"}, DW'(tri_last), DW'(beats == n - 1));
                    if (mode == 0) chk({tag, "_beat_cycle"}, DW'(k), DW'(beats + 2));
                end else begin
                    chk({tag, "_extra_beat"}, DW'(beats + 1), DW'(n));
                end
                beats++;
            end
            pvalid = tri_valid; pdata = tri_data; plast = tri_last;
        end
        wr_en = 1'b0;
        chk({tag, "_done_seen"}, DW'(done_k >= 0), DW'(1));
        @(negedge clk);
        chk({tag, "_done_pulse"}, DW'(done), DW'(0));
        chk({tag, "_idle_valid"}, DW'(tri_valid), DW'(0));
        tri_ready = 1'b0;
        $display("stream %s: beats=%0d expected=%0d done_k=%0d", tag, beats, n, done_k);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", DW'(tri_valid), DW'(0));
        chk("rst_last", DW'(tri_last), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_count", DW'(tri_count), DW'(0));
        chk("rst_ovf", DW'(ovf), DW'(0));

        // Five fixed triangles, one rewritten to confirm the count keeps the maximum
        for (int i = 0; i < 5; i++) wr(32'(i), DW'(8'hA0 + i), i == 0);
        wr(32'd2, DW'(8'hA2), 1'b0);
        check_regs("a");
        run_stream(0, 1'b0, "a");

        // Three random triangles written out of order, consumer stalls
        wr(32'd2, rnd(), 1'b1);
        wr(32'd0, rnd(), 1'b0);
        wr(32'd1, rnd(), 1'b0);
        check_regs("b");
        run_stream(1, 1'b0, "b");

        // Dropped writes: out of range, high-bit alias, and while streaming
        wr(32'(DEPTH), rnd(), 1'b0);
        wr(32'h0001_0001, rnd(), 1'b0);
        check_regs("c");
        run_stream(2, 1'b1, "c_busy");
        check_regs("c_after");
        run_stream(0, 1'b0, "c_reread");
        clr_load();
        check_regs("c_clr");
        wr(32'd6, rnd(), 1'b1);
        check_regs("c_clr_wr");

        // Fill every slot and stream them all
        for (int i = 0; i < DEPTH; i++) wr(32'(i), rnd(), i == 0);
        check_regs("full");
        run_stream(0, 1'b0, "full");

        // Empty store
        clr_load();
        check_regs("empty");
        run_stream(0, 1'b0, "empty");

        // Reset in the middle of a stream
        for (int i = 0; i < 8; i++) wr(32'(i), rnd(), i == 0);
        @(negedge clk);
        start = 1'b1; tri_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_valid_before", DW'(tri_valid), DW'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_count = 0; model_ovf = 1'b0;
        chk("mid_valid", DW'(tri_valid), DW'(0));
        chk("mid_last", DW'(tri_last), DW'(0));
        chk("mid_busy", DW'(busy), DW'(0));
        chk("mid_count", DW'(tri_count), DW'(model_count));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mid_no_done", DW'(done), DW'(0));
            chk("mid_no_valid", DW'(tri_valid), DW'(0));
        end
        $display("mid-stream reset checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
